// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: widths, reset PC,
// nop encoding and the per-edge action decode used by the top level.
package fetch_stage_pkg;

  localparam int                FETCH_PC_W     = 12;
  localparam int                INSTR_W        = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR     = 32'h0;
  localparam int                FETCH_RESET_PC = 0;
  localparam int                PERF_W         = 32;

  // What the stage does on a given rising edge
  typedef enum logic [1:0] {
    ACT_ADVANCE  = 2'd0,
    ACT_STALL    = 2'd1,
    ACT_REDIRECT = 2'd2
  } fetch_action_e;

  // Redirect beats stall beats advance
  function automatic fetch_action_e decode_action(input logic redirect,
                                                  input logic stall);
    fetch_action_e act;
    if (redirect) begin
      act = ACT_REDIRECT;
    end else if (stall) begin
      act = ACT_STALL;
    end else begin
      act = ACT_ADVANCE;
    end
    return act;
  endfunction

endpackage

// File: rtl/fetch_stage_perf_counters.sv
// Fetch performance counters: delivered instructions and stall cycles.
// Only instantiated by fetch_stage when FETCH_PERF_EN is defined.
module fetch_perf_counters
  import fetch_stage_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              i_advance,
  input  logic              i_stall,
  output logic [PERF_W-1:0] o_fetched,
  output logic [PERF_W-1:0] o_stalls
);

  logic [PERF_W-1:0] r_fetched;
  logic [PERF_W-1:0] r_stalls;

  // Free-running 32-bit counters, wrap naturally, cleared by reset
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_fetched <= '0;
      r_stalls  <= '0;
    end else begin
      if (i_advance) begin
        r_fetched <= r_fetched + PERF_W'(1);
      end
      if (i_stall) begin
        r_stalls <= r_stalls + PERF_W'(1);
      end
    end
  end

  assign o_fetched = r_fetched;
  assign o_stalls  = r_stalls;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the imem address and loads
// the IF/ID register. The imem is read on the falling edge, so the word for
// the PC presented at one rising edge is captured at the next rising edge.
// Optional feature macro: FETCH_PERF_EN adds perf_fetched / perf_stalls.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(FETCH_RESET_PC)
) (
  input  logic               clock,
  input  logic               reset,
  output logic [PC_W-1:0]    address_imem,
  input  logic [INSTR_W-1:0] q_imem,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_target,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [PC_W-1:0]    id_pc,
  output logic [PC_W-1:0]    id_pc_plus1
`ifdef FETCH_PERF_EN
  ,
  output logic [PERF_W-1:0]  perf_fetched,
  output logic [PERF_W-1:0]  perf_stalls
`endif
);

  fetch_action_e       w_action;
  logic [PC_W-1:0]     w_pc_plus1;

  logic [PC_W-1:0]     r_pc;
  logic                r_id_valid;
  logic [INSTR_W-1:0]  r_id_instr;
  logic [PC_W-1:0]     r_id_pc;
  logic [PC_W-1:0]     r_id_pc_plus1;

  logic [PC_W-1:0]     w_pc_next;
  logic                w_id_valid_next;
  logic [INSTR_W-1:0]  w_id_instr_next;
  logic [PC_W-1:0]     w_id_pc_next;
  logic [PC_W-1:0]     w_id_pc_plus1_next;

  assign w_action   = decode_action(redirect, stall);
  // Modulo PC_W: the top word wraps to zero
  assign w_pc_plus1 = r_pc + PC_W'(1);

  // Next-state selection; a stall simply keeps every register as is
  always_comb begin
    w_pc_next          = r_pc;
    w_id_valid_next    = r_id_valid;
    w_id_instr_next    = r_id_instr;
    w_id_pc_next       = r_id_pc;
    w_id_pc_plus1_next = r_id_pc_plus1;
    case (w_action)
      ACT_REDIRECT: begin
        // The word fetched from the old path is wrong-path: drop it
        w_pc_next       = redirect_target;
        w_id_valid_next = 1'b0;
        w_id_instr_next = NOP_INSTR;
      end
      ACT_ADVANCE: begin
        w_pc_next          = w_pc_plus1;
        w_id_valid_next    = 1'b1;
        w_id_instr_next    = q_imem;
        w_id_pc_next       = r_pc;
        w_id_pc_plus1_next = w_pc_plus1;
      end
      default: begin
      end
    endcase
  end

  // PC and IF/ID register, asynchronously cleared
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_pc          <= RESET_PC;
      r_id_valid    <= 1'b0;
      r_id_instr    <= NOP_INSTR;
      r_id_pc       <= '0;
      r_id_pc_plus1 <= '0;
    end else begin
      r_pc          <= w_pc_next;
      r_id_valid    <= w_id_valid_next;
      r_id_instr    <= w_id_instr_next;
      r_id_pc       <= w_id_pc_next;
      r_id_pc_plus1 <= w_id_pc_plus1_next;
    end
  end

  assign address_imem = r_pc;
  assign id_valid     = r_id_valid;
  assign id_instr     = r_id_instr;
  assign id_pc        = r_id_pc;
  assign id_pc_plus1  = r_id_pc_plus1;

`ifdef FETCH_PERF_EN
  fetch_perf_counters u_perf (
    .clock     (clock),
    .reset     (reset),
    .i_advance (w_action == ACT_ADVANCE),
    .i_stall   (w_action == ACT_STALL),
    .o_fetched (perf_fetched),
    .o_stalls  (perf_stalls)
  );
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage. A driver issues one action per cycle on
// the falling edge and pushes the IF/ID state the stage should show after the
// next rising edge; a monitor pops and compares just after each rising edge.
module tb_fetch_stage;

  localparam int PCW  = 12;
  localparam int NPC  = 4096;

  logic            clock = 1'b0;
  logic            reset = 1'b0;
  logic [PCW-1:0]  address_imem;
  logic [31:0]     q_imem = 32'h0;
  logic            stall = 1'b0;
  logic            redirect = 1'b0;
  logic [PCW-1:0]  redirect_target = '0;
  logic            id_valid;
  logic [31:0]     id_instr;
  logic [PCW-1:0]  id_pc;
  logic [PCW-1:0]  id_pc_plus1;
`ifdef FETCH_PERF_EN
  logic [31:0]     perf_fetched;
  logic [31:0]     perf_stalls;
`endif

  fetch_stage dut (
    .clock           (clock),
    .reset           (reset),
    .address_imem    (address_imem),
    .q_imem          (q_imem),
    .stall           (stall),
    .redirect        (redirect),
    .redirect_target (redirect_target),
    .id_valid        (id_valid),
    .id_instr        (id_instr),
    .id_pc           (id_pc),
    .id_pc_plus1     (id_pc_plus1)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched    (perf_fetched),
    .perf_stalls     (perf_stalls)
`endif
  );

  always #5 clock = ~clock;

  // Synchronous ROM read on the falling edge
  logic [31:0] mem [0:NPC-1];
  always @(negedge clock) q_imem <= mem[address_imem];

  typedef struct {
    bit          valid;
    logic [31:0] instr;
    int          pc;
    int          plus1;
    int          addr;
    int          fetched;
    int          stalls;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_txn    = 0;
  bit   started  = 1'b0;
  bit   done     = 1'b0;

  // Reference model: the architectural view of the stage
  int          m_pc;
  bit          m_valid;
  logic [31:0] m_instr;
  int          m_id_pc, m_plus1, m_fetched, m_stalls;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_pc = 0; m_valid = 0; m_instr = 32'h0; m_id_pc = 0; m_plus1 = 0;
    m_fetched = 0; m_stalls = 0;
  endfunction

  function automatic void push_exp();
    exp_t e;
    e.valid = m_valid; e.instr = m_instr; e.pc = m_id_pc; e.plus1 = m_plus1;
    e.addr = m_pc; e.fetched = m_fetched; e.stalls = m_stalls;
    sb_q.push_back(e);
    started = 1'b1;
  endfunction

  // One reset-held cycle
  task automatic rst_step();
    @(negedge clock);
    reset = 1'b0;
    model_reset();
    push_exp();
  endtask

  // One active cycle: drive inputs, then predict the edge's effect
  task automatic step(input bit st, input bit rd, input int tgt);
    @(negedge clock);
    reset = 1'b1;
    stall = st;
    redirect = rd;
    redirect_target = PCW'(tgt);
    if (rd) begin
      m_pc = tgt % NPC;
      m_valid = 0;
      m_instr = 32'h0;
    end else if (st) begin
      m_stalls++;
    end else begin
      m_valid = 1;
      m_instr = mem[m_pc];
      m_id_pc = m_pc;
      m_plus1 = (m_pc + 1) % NPC;
      m_pc = (m_pc + 1) % NPC;
      m_fetched++;
    end
    push_exp();
  endtask

  task automatic idle_until_pc(input int target_pc);
    for (int i = 0; i < NPC + 2 && m_pc != target_pc; i++) step(0, 0, 0);
  endtask

  // Asynchronous reset asserted between edges, checked before the next edge
  task automatic mid_reset();
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    chk("async_addr", 32'(address_imem), 32'h0);
    chk("async_valid", 32'(id_valid), 32'h0);
    chk("async_instr", id_instr, 32'h0);
    chk("async_id_pc", 32'(id_pc), 32'h0);
    chk("async_plus1", 32'(id_pc_plus1), 32'h0);
`ifdef FETCH_PERF_EN
    chk("async_fetched", perf_fetched, 32'h0);
    chk("async_stalls", perf_stalls, 32'h0);
`endif
    model_reset();
    @(negedge clock);
    push_exp();
  endtask

  // Monitor: compare the DUT against the oldest prediction after each edge
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (started && !done) begin
        if (sb_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL sb_underflow: got empty queue expected an entry");
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          n_txn++;
          $display("txn %0d: valid=%0d id_pc=%03h instr=%08h plus1=%03h addr=%03h",
                   n_txn, id_valid, id_pc, id_instr, id_pc_plus1, address_imem);
          chk("id_valid", 32'(id_valid), 32'(e.valid));
          chk("id_instr", id_instr, e.instr);
          chk("id_pc", 32'(id_pc), 32'(e.pc));
          chk("id_pc_plus1", 32'(id_pc_plus1), 32'(e.plus1));
          chk("address_imem", 32'(address_imem), 32'(e.addr));
`ifdef FETCH_PERF_EN
          chk("perf_fetched", perf_fetched, 32'(e.fetched));
          chk("perf_stalls", perf_stalls, 32'(e.stalls));
`endif
        end
      end
    end
  end

  // Watchdog
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected end of stimulus");
    $fatal(1, "watchdog expired");
  end

  // Stimulus
  initial begin
    for (int k = 0; k < NPC; k++) mem[k] = 32'h100 + k;
    model_reset();

    rst_step();
    rst_step();
    // Reset release and straight-line fetch
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    // Stall three cycles with pc=5
    idle_until_pc(5);
    for (int i = 0; i < 3; i++) step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    // Redirect at pc=7
    idle_until_pc(7);
    step(0, 1, 'h200);
    step(0, 0, 0);
    step(0, 0, 0);
    // Redirect together with stall
    step(1, 1, 'h10);
    step(0, 0, 0);
    // PC wrap
    step(0, 1, 'hFFD);
    for (int i = 0; i < 6; i++) step(0, 0, 0);
    // Randomized mix
    for (int i = 0; i < 300; i++) begin
      int r, tgt;
      r = int'($urandom_range(0, 99));
      tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(4088, 4095))
                                        : int'($urandom_range(0, 4095));
      step(r < 25, r >= 88, tgt);
    end
    // Reset mid-stream, then resume
    mid_reset();
    rst_step();
    for (int i = 0; i < 40; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      step(r < 20, r >= 90, int'($urandom_range(0, 4095)));
    end

    @(posedge clock);
    #2;
    done = 1'b1;
    chk("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
